// File: rtl/dehaze_pkg.sv
// Shared types and constants for the dehaze frame controller: FSM encoding,
// widths, default image geometry and the A smoothing helper.
package dehaze_pkg;
   localparam int A_W       = 8;
   localparam int FCNT_W    = 16;
   localparam int IMG_H_DEF = 640;
   localparam int IMG_V_DEF = 480;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WARMUP = 2'd1;
   localparam logic [1:0] RUN    = 2'd2;
   localparam logic [1:0] RESYNC = 2'd3;

   // (3*old + new + 2) >> 2 with a 10-bit accumulator; max sum 1022 never overflows
   function automatic logic [A_W-1:0] a_blend(input logic [A_W-1:0] old_a,
                                              input logic [A_W-1:0] new_a);
      logic [A_W+1:0] acc;
      acc = {2'b00, old_a} + {1'b0, old_a, 1'b0} + {2'b00, new_a} + 10'd2;
      return acc[A_W+1:2];
   endfunction
endpackage

// File: rtl/dehaze_frame_ctrl_geom.sv
// Frame geometry checker: vsync/href edge detection, pixel/line counting and
// the sticky frame_err flag when a line or frame disagrees with the parameters.
module frame_geom_chk
   import dehaze_pkg::*;
#(
   parameter int IMG_H_DISP = IMG_H_DEF,
   parameter int IMG_V_DISP = IMG_V_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync,
   input  logic href,
   input  logic clken,
   output logic vs_rise,
   output logic vs_fall,
   output logic frame_err
);
   localparam logic [15:0] H_L = 16'(IMG_H_DISP);
   localparam logic [15:0] V_L = 16'(IMG_V_DISP);

   logic        vs_d, hs_d, armed;
   logic [15:0] pix_cnt, line_cnt, line_nxt;
   logic        hs_fall;

   // armed stays low until vsync is seen low, so a frame cut by reset is ignored
   assign vs_rise  = armed & vsync & ~vs_d;
   assign vs_fall  = armed & vs_d & ~vsync;
   assign hs_fall  = armed & hs_d & ~href;
   // include a line ending in the same cycle as the frame
   assign line_nxt = line_cnt + {15'd0, hs_fall};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d      <= 1'b0;
         hs_d      <= 1'b0;
         armed     <= 1'b0;
         pix_cnt   <= '0;
         line_cnt  <= '0;
         frame_err <= 1'b0;
      end else begin
         vs_d <= vsync;
         hs_d <= href;
         if (!vsync) armed <= 1'b1;

         if (hs_fall) begin
            pix_cnt <= '0;
            if (pix_cnt != H_L) frame_err <= 1'b1;
         end else if (armed && href && clken) begin
            pix_cnt <= pix_cnt + 16'd1;
         end

         if (vs_fall) begin
            line_cnt <= '0;
            if (line_nxt != V_L) frame_err <= 1'b1;
         end else if (hs_fall) begin
            line_cnt <= line_nxt;
         end
      end
   end
endmodule

// File: rtl/dehaze_frame_ctrl.sv
// Frame scheduler for haze-removal recovery: shadows A and commits it at frame
// start, gates recovery until A exists, checks src/tx clken alignment.
// Optional: DEHAZE_A_IIR_EN smooths A across commits after the first one.
module dehaze_frame_ctrl
   import dehaze_pkg::*;
#(
   parameter int             IMG_H_DISP = IMG_H_DEF,
   parameter int             IMG_V_DISP = IMG_V_DEF,
   parameter logic [A_W-1:0] A_DEFAULT  = 8'd255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              per_src_frame_vsync,
   input  logic              per_src_frame_href,
   input  logic              per_src_frame_clken,
   input  logic              per_tx_frame_clken,
   input  logic [A_W-1:0]    A_cand,
   input  logic              A_valid,
   output logic [A_W-1:0]    post_A,
   output logic              recover_en,
   output logic              frame_start,
   output logic              align_err,
   output logic              frame_err,
   output logic [FCNT_W-1:0] frame_cnt
);
   logic [1:0]     state, state_nxt;
   logic [A_W-1:0] shadow_A, commit_src, a_next;
   logic           shadow_vld, commit, vs_rise, vs_fall, mis_run;

   frame_geom_chk #(
      .IMG_H_DISP (IMG_H_DISP),
      .IMG_V_DISP (IMG_V_DISP)
   ) u_geom (
      .clk       (clk),
      .rst_n     (rst_n),
      .vsync     (per_src_frame_vsync),
      .href      (per_src_frame_href),
      .clken     (per_src_frame_clken),
      .vs_rise   (vs_rise),
      .vs_fall   (vs_fall),
      .frame_err (frame_err)
   );

   // a strobe coinciding with the frame edge wins over the stored shadow
   assign commit_src = A_valid ? A_cand : shadow_A;
   assign mis_run    = (state == RUN) & per_src_frame_vsync &
                       (per_src_frame_clken ^ per_tx_frame_clken);

`ifdef DEHAZE_A_IIR_EN
   assign a_next = (state == WARMUP) ? commit_src : a_blend(post_A, commit_src);
`else
   assign a_next = commit_src;
`endif

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      case (state)
         IDLE:   if (vs_rise) state_nxt = WARMUP;
         WARMUP: if (vs_rise && (shadow_vld || A_valid)) begin
                    commit    = 1'b1;
                    state_nxt = RUN;
                 end
         RUN: begin
                 if (vs_rise) commit    = 1'b1;
                 if (mis_run) state_nxt = RESYNC;
              end
         default: if (vs_rise) begin
                    commit    = 1'b1;
                    state_nxt = RUN;
                 end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shadow_A    <= A_DEFAULT;
         shadow_vld  <= 1'b0;
         post_A      <= A_DEFAULT;
         recover_en  <= 1'b0;
         frame_start <= 1'b0;
         align_err   <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         state       <= state_nxt;
         frame_start <= vs_rise;
         // follows the registered state, so it lags each transition by a cycle
         recover_en  <= (state == RUN);
         if (A_valid) begin
            shadow_A   <= A_cand;
            shadow_vld <= 1'b1;
         end
         if (commit)  post_A    <= a_next;
         if (mis_run) align_err <= 1'b1;
         if (vs_fall) frame_cnt <= frame_cnt + 16'd1;
      end
   end
endmodule
